// File: rtl/dsp_sequencer.sv
// -----------------------------------------------------------------------------
// dsp_sequencer
// -----------------------------------------------------------------------------
// Fetch/decode/execute sequencer for the DSP core. Owns the program counter,
// the instruction register and the operand-word register. Presents the IR to
// the control-word LUT and lets the LUT's state-changing strobes through only
// in the single EXECUTE cycle of each instruction.
//
// Instruction flow:
//   FETCH -> DECODE -> EXECUTE                 single-word instruction
//   FETCH -> DECODE -> FETCH2 -> EXECUTE       two-word branch (pcInMux_ctrl=00)
//   EXECUTE -> HALT when halt_req is high at the instruction boundary
//
// Parameters:
//   PC_W       program address width (PC wraps modulo 2**PC_W)
//   RESET_VEC  PC value loaded on reset
//
// Ports:
//   clk           in   1     core clock, rising edge
//   reset_n       in   1     asynchronous active-low reset
//   pm_req        out  1     program-memory read request
//   pm_addr       out  PC_W  program-memory address (the PC)
//   pm_ack        in   1     read complete, pm_data valid this cycle
//   pm_data       in   16    instruction/operand word
//   instruction   out  16    IR, to LUT
//   op_dk         out  8     IR[15:8], to LUT
//   op_s          out  4     IR[15:12], to LUT
//   pcInMux_ctrl  in   2     11=PC+1, 00=two-word branch, 01=PC<-acc_lo, 10=PC-1
//   branch_cond   in   1     branch condition, used in EXECUTE for 00
//   acc_lo        in   PC_W  computed-branch target
//   raw_strobe    in   6     LUT {tReg,pReg,load_acc,enable_acc,dataWr,dp}
//   exec_strobe   out  6     raw_strobe in EXECUTE, else 0
//   operand       out  16    second word of a two-word instruction
//   halt_req      in   1     halt at the next instruction boundary
//   halted        out  1     high while in HALT
//   retire        out  1     high in each EXECUTE cycle
//   step          in   1     (DSP_SEQ_SINGLE_STEP_EN only) rising edge in HALT
//                            runs exactly one instruction
//
// Configuration macro: DSP_SEQ_SINGLE_STEP_EN
//   defined   -> adds the step input and single-step support from HALT
//   undefined -> HALT is left only when halt_req deasserts
// -----------------------------------------------------------------------------
module dsp_sequencer #(
  parameter int              PC_W      = 12,
  parameter logic [PC_W-1:0] RESET_VEC = {PC_W{1'b0}}
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            pm_req,
  output logic [PC_W-1:0] pm_addr,
  input  logic            pm_ack,
  input  logic [15:0]     pm_data,
  output logic [15:0]     instruction,
  output logic [7:0]      op_dk,
  output logic [3:0]      op_s,
  input  logic [1:0]      pcInMux_ctrl,
  input  logic            branch_cond,
  input  logic [PC_W-1:0] acc_lo,
  input  logic [5:0]      raw_strobe,
  output logic [5:0]      exec_strobe,
  output logic [15:0]     operand,
  input  logic            halt_req,
  output logic            halted,
`ifdef DSP_SEQ_SINGLE_STEP_EN
  input  logic            step,
`endif
  output logic            retire
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_FETCH2  = 3'd2,
    S_EXECUTE = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  logic [PC_W-1:0]   r_pc;
  logic [15:0]       r_ir;
  logic [15:0]       r_operand;
  logic              r_pm_req;
  logic              r_retire;
  logic              r_halted;

  state_t            w_state_nxt;
  logic [PC_W-1:0]   w_pc_nxt;
  logic [15:0]       w_ir_nxt;
  logic [15:0]       w_operand_nxt;
  logic              w_ack;

`ifdef DSP_SEQ_SINGLE_STEP_EN
  logic              r_step_q;
  logic              r_step_mode;
  logic              w_step_rise;
  logic              w_step_mode_nxt;
`endif

  // An ack only counts while our request is actually on the bus, so a late
  // ack from a handshake that reset cut short is dropped.
  assign w_ack = pm_ack & r_pm_req;

`ifdef DSP_SEQ_SINGLE_STEP_EN
  assign w_step_rise = step & ~r_step_q;
`endif

  // Next-state, PC, IR and operand selection.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_ir_nxt      = r_ir;
    w_operand_nxt = r_operand;
`ifdef DSP_SEQ_SINGLE_STEP_EN
    w_step_mode_nxt = r_step_mode;
`endif
    case (r_state)
      S_FETCH: begin
        if (w_ack) begin
          w_ir_nxt    = pm_data;
          w_pc_nxt    = r_pc + PC_ONE;
          w_state_nxt = S_DECODE;
        end else begin
          w_state_nxt = S_FETCH;
        end
      end
      S_DECODE: begin
        // The LUT has had one full cycle on the new IR; 00 needs the operand.
        if (pcInMux_ctrl == 2'b00) begin
          w_state_nxt = S_FETCH2;
        end else begin
          w_state_nxt = S_EXECUTE;
        end
      end
      S_FETCH2: begin
        if (w_ack) begin
          w_operand_nxt = pm_data;
          w_pc_nxt      = r_pc + PC_ONE;
          w_state_nxt   = S_EXECUTE;
        end else begin
          w_state_nxt = S_FETCH2;
        end
      end
      S_EXECUTE: begin
        // PC already points past the instruction (and operand, if any).
        case (pcInMux_ctrl)
          2'b11: w_pc_nxt = r_pc;
          2'b00: begin
            if (branch_cond) begin
              w_pc_nxt = r_operand[PC_W-1:0];
            end else begin
              w_pc_nxt = r_pc;
            end
          end
          2'b01: w_pc_nxt = acc_lo;
          2'b10: w_pc_nxt = r_pc - PC_ONE;
          default: w_pc_nxt = r_pc;
        endcase
`ifdef DSP_SEQ_SINGLE_STEP_EN
        if (r_step_mode) begin
          w_step_mode_nxt = 1'b0;
          w_state_nxt     = S_HALT;
        end else if (halt_req) begin
          w_state_nxt = S_HALT;
        end else begin
          w_state_nxt = S_FETCH;
        end
`else
        if (halt_req) begin
          w_state_nxt = S_HALT;
        end else begin
          w_state_nxt = S_FETCH;
        end
`endif
      end
      S_HALT: begin
`ifdef DSP_SEQ_SINGLE_STEP_EN
        if (!halt_req) begin
          w_state_nxt = S_FETCH;
        end else if (w_step_rise) begin
          // Run one instruction, then come back here whatever halt_req does.
          w_step_mode_nxt = 1'b1;
          w_state_nxt     = S_FETCH;
        end else begin
          w_state_nxt = S_HALT;
        end
`else
        if (!halt_req) begin
          w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = S_HALT;
        end
`endif
      end
      default: begin
        // Illegal encoding: restart the fetch cycle at the current PC.
        w_state_nxt = S_FETCH;
      end
    endcase
  end

  // State, architectural registers and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_VEC;
      r_ir      <= 16'h0000;
      r_operand <= 16'h0000;
      r_pm_req  <= 1'b0;
      r_retire  <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_ir      <= w_ir_nxt;
      r_operand <= w_operand_nxt;
      // Status flags are computed from the next state so they line up
      // exactly with the state they describe.
      r_pm_req  <= (w_state_nxt == S_FETCH) || (w_state_nxt == S_FETCH2);
      r_retire  <= (w_state_nxt == S_EXECUTE);
      r_halted  <= (w_state_nxt == S_HALT);
    end
  end

`ifdef DSP_SEQ_SINGLE_STEP_EN
  // Step edge detector and single-step flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_step_q    <= 1'b0;
      r_step_mode <= 1'b0;
    end else begin
      r_step_q    <= step;
      r_step_mode <= w_step_mode_nxt;
    end
  end
`endif

  assign pm_req      = r_pm_req;
  assign pm_addr     = r_pc;
  assign instruction = r_ir;
  assign op_dk       = r_ir[15:8];
  assign op_s        = r_ir[15:12];
  assign operand     = r_operand;
  assign retire      = r_retire;
  assign halted      = r_halted;
  // retire is high exactly in EXECUTE, so it doubles as the strobe gate.
  assign exec_strobe = raw_strobe & {6{r_retire}};

endmodule

// File: tb/tb_dsp_sequencer.sv
module tb_dsp_sequencer;
  localparam int PC_W = 12;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            pm_req;
  logic [PC_W-1:0] pm_addr;
  logic            pm_ack;
  logic [15:0]     pm_data;
  logic [15:0]     instruction;
  logic [7:0]      op_dk;
  logic [3:0]      op_s;
  logic [1:0]      pcInMux_ctrl;
  logic            branch_cond;
  logic [PC_W-1:0] acc_lo;
  logic [5:0]      raw_strobe;
  logic [5:0]      exec_strobe;
  logic [15:0]     operand;
  logic            halt_req;
  logic            halted;
  logic            retire;
`ifdef DSP_SEQ_SINGLE_STEP_EN
  logic            step;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] mem [0:4095];
  int  wait_fixed;
  bit  rand_wait, spurious_en, mon_en, rand_halt_en;
  logic rep_done;

  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] op;
    logic [5:0]  stb;
  } ret_t;
  logic [PC_W-1:0] exp_fetch_q[$];
  ret_t            exp_ret_q[$];

  always #5 clk = ~clk;

  // Stand-in for the control-word LUT and datapath: everything is a function
  // of IR. A repeat instruction (10) repeats exactly once, then acts as 11.
  assign pcInMux_ctrl = (instruction[1:0] == 2'b10 && rep_done) ? 2'b11 : instruction[1:0];
  assign raw_strobe   = instruction[7:2];
  assign branch_cond  = instruction[8];
  assign acc_lo       = instruction[15:4];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) rep_done <= 1'b0;
    else if (retire) rep_done <= (pcInMux_ctrl == 2'b10);
  end

  dsp_sequencer #(.PC_W(PC_W), .RESET_VEC(12'h000)) dut (
    .clk(clk), .reset_n(reset_n), .pm_req(pm_req), .pm_addr(pm_addr),
    .pm_ack(pm_ack), .pm_data(pm_data), .instruction(instruction),
    .op_dk(op_dk), .op_s(op_s), .pcInMux_ctrl(pcInMux_ctrl),
    .branch_cond(branch_cond), .acc_lo(acc_lo), .raw_strobe(raw_strobe),
    .exec_strobe(exec_strobe), .operand(operand), .halt_req(halt_req),
    .halted(halted),
`ifdef DSP_SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .retire(retire)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: expected event did not occur at %0t", name, $time);
  endtask

  // Program-memory responder: acks after a configurable number of wait
  // cycles; optionally throws random acks while no request is pending.
  initial begin : responder
    int waited;
    int target;
    pm_ack = 1'b0; pm_data = 16'h0000; waited = 0; target = 0;
    forever begin
      @(negedge clk);
      if (reset_n && pm_req) begin
        if (waited >= target) begin
          pm_ack  = 1'b1;
          pm_data = mem[pm_addr];
          waited  = 0;
          target  = rand_wait ? int'($urandom_range(0, 3)) : wait_fixed;
        end else begin
          pm_ack = 1'b0;
          waited++;
        end
      end else begin
        waited  = 0;
        target  = rand_wait ? int'($urandom_range(0, 3)) : wait_fixed;
        pm_ack  = spurious_en ? 1'($urandom_range(0, 1)) : 1'b0;
        pm_data = 16'($urandom);
      end
    end
  end

  // Scoreboard monitor: pops expectations whenever the DUT fetches or retires.
  initial begin : monitor
    logic [PC_W-1:0] ea;
    ret_t            er;
    forever begin
      @(negedge clk);
      if (mon_en && reset_n) begin
        if (pm_req && pm_ack) begin
          if (exp_fetch_q.size() == 0) fail_now("fetch_queue_empty");
          else begin
            ea = exp_fetch_q.pop_front();
            chk("fetch_addr", 32'(pm_addr), 32'(ea));
          end
        end
        if (retire) begin
          if (exp_ret_q.size() == 0) fail_now("retire_queue_empty");
          else begin
            er = exp_ret_q.pop_front();
            chk("retire_ir", 32'(instruction), 32'(er.ir));
            chk("retire_operand", 32'(operand), 32'(er.op));
            chk("retire_strobe", 32'(exec_strobe), 32'(er.stb));
          end
        end else begin
          chk("strobe_idle", 32'(exec_strobe), 32'h0);
        end
        if (halted) chk("halt_no_req", 32'(pm_req), 32'h0);
      end
    end
  end

  // Random halt requests during the random runs.
  initial begin : halt_gen
    forever begin
      @(negedge clk);
      if (rand_halt_en && $urandom_range(0, 19) == 0) halt_req = ~halt_req;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Architectural reference: runs the program straight through memory and
  // records every expected fetch address and every retirement.
  task automatic build_model(input int n);
    logic [PC_W-1:0] pc;
    logic [15:0]     ir, opreg;
    logic [1:0]      m;
    bit              prev_rep;
    ret_t            r;
    pc = 12'h000; opreg = 16'h0000; prev_rep = 1'b0;
    for (int k = 0; k < n; k++) begin
      exp_fetch_q.push_back(pc);
      ir = mem[pc];
      pc = pc + 12'd1;
      m  = ir[1:0];
      if (m == 2'b10 && prev_rep) m = 2'b11;
      if (m == 2'b00) begin
        exp_fetch_q.push_back(pc);
        opreg = mem[pc];
        pc    = pc + 12'd1;
      end
      r.ir = ir; r.op = opreg; r.stb = ir[7:2];
      exp_ret_q.push_back(r);
      if (m == 2'b00 && ir[8]) pc = opreg[PC_W-1:0];
      else if (m == 2'b01)     pc = ir[15:4];
      else if (m == 2'b10)     pc = pc - 12'd1;
      prev_rep = (m == 2'b10);
    end
  endtask

  task automatic fill_mem(input logic [15:0] v);
    for (int i = 0; i < 4096; i++) mem[i] = v;
  endtask

  // Assert reset for three cycles; ends on a falling edge with reset still low.
  task automatic hold_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    exp_fetch_q.delete();
    exp_ret_q.delete();
  endtask

  task automatic wait_retires(input int n, input int budget, output bit ok);
    int cnt = 0;
    int c   = 0;
    while (c < budget && cnt < n) begin
      @(posedge clk); #1;
      c++;
      if (retire) cnt++;
    end
    ok = (cnt == n);
  endtask

  logic [15:0]     d_insn [3] = '{16'h1233, 16'h1231, 16'h0002};
  logic [PC_W-1:0] d_exp  [3] = '{12'h000, 12'h123, 12'hFFF};

  initial begin : main
    bit ok;
    int cnt;
    reset_n = 1'b0; halt_req = 1'b0; wait_fixed = 0;
    rand_wait = 1'b0; spurious_en = 1'b0; mon_en = 1'b0; rand_halt_en = 1'b0;
`ifdef DSP_SEQ_SINGLE_STEP_EN
    step = 1'b0;
`endif

    // Zero-wait single-word instruction; checks reset values and 3-cycle timing.
    fill_mem(16'h7F8F);
    hold_reset();
    chk("rst_pm_req", 32'(pm_req), 32'h0);
    chk("rst_pm_addr", 32'(pm_addr), 32'h0);
    chk("rst_ir", 32'(instruction), 32'h0);
    chk("rst_operand", 32'(operand), 32'h0);
    chk("rst_retire", 32'(retire), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_strobe", 32'(exec_strobe), 32'h0);
    reset_n = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      chk("a_retire", 32'(retire), (c == 3) ? 32'h1 : 32'h0);
      chk("a_strobe", 32'(exec_strobe), (c == 3) ? 32'h23 : 32'h0);
      if (c == 1) begin
        chk("a_req1", 32'(pm_req), 32'h1);
        chk("a_addr1", 32'(pm_addr), 32'h0);
      end
      if (c == 4) begin
        chk("a_req4", 32'(pm_req), 32'h1);
        chk("a_addr4", 32'(pm_addr), 32'h1);
      end
    end

    // Three memory wait cycles: address held, retire in cycle 6.
    wait_fixed = 3;
    hold_reset();
    reset_n = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      chk("b_retire", 32'(retire), (c == 6) ? 32'h1 : 32'h0);
      if (c <= 4) begin
        chk("b_req", 32'(pm_req), 32'h1);
        chk("b_addr", 32'(pm_addr), 32'h0);
      end
      if (c < 6) chk("b_strobe", 32'(exec_strobe), 32'h0);
    end

    // Two-word branch at PC=5, taken and not taken.
    wait_fixed = 0;
    for (int t = 0; t < 2; t++) begin
      fill_mem(16'h0003);
      mem[5] = (t == 0) ? 16'h0100 : 16'h0000;
      mem[6] = 16'h0020;
      hold_reset();
      reset_n = 1'b1;
      wait_retires(6, 60, ok);
      if (!ok) fail_now("c_retire_timeout");
      chk("c_operand", 32'(operand), 32'h0020);
      @(posedge clk); #1;
      chk("c_next_addr", 32'(pm_addr), (t == 0) ? 32'h020 : 32'h007);
    end

    // PC wrap and computed branch from address 0xFFF.
    for (int t = 0; t < 3; t++) begin
      fill_mem(16'h0003);
      mem[0]     = 16'hFFF1;
      mem[12'hFFF] = d_insn[t];
      hold_reset();
      reset_n = 1'b1;
      wait_retires(1, 20, ok);
      if (!ok) fail_now("d_retire_timeout");
      @(posedge clk); #1;
      chk("d_addr_fff", 32'(pm_addr), 32'hFFF);
      wait_retires(1, 20, ok);
      if (!ok) fail_now("d_retire2_timeout");
      @(posedge clk); #1;
      chk("d_next_addr", 32'(pm_addr), 32'(d_exp[t]));
    end

    // Halt raised during FETCH: instruction completes, then halt, then resume.
    fill_mem(16'h0003);
    wait_fixed = 2;
    hold_reset();
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("e_in_fetch", 32'(pm_req), 32'h1);
    halt_req = 1'b1;
    wait_retires(1, 20, ok);
    if (!ok) fail_now("e_retire_timeout");
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("e_halted", 32'(halted), 32'h1);
      chk("e_no_req", 32'(pm_req), 32'h0);
      chk("e_no_retire", 32'(retire), 32'h0);
    end
    halt_req = 1'b0;
    @(posedge clk); #1;
    chk("e_unhalted", 32'(halted), 32'h0);
    chk("e_resume_req", 32'(pm_req), 32'h1);
    chk("e_resume_addr", 32'(pm_addr), 32'h1);

    // Reset pulsed during FETCH2.
    mem[0] = 16'h0100;
    mem[1] = 16'h0040;
    hold_reset();
    reset_n = 1'b1;
    cnt = 0;
    while (cnt < 20 && !(pm_req && instruction == 16'h0100)) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (cnt >= 20) fail_now("f_fetch2_timeout");
    reset_n = 1'b0;
    #1;
    chk("f_req", 32'(pm_req), 32'h0);
    chk("f_pc", 32'(pm_addr), 32'h0);
    chk("f_ir", 32'(instruction), 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("f_no_retire", 32'(retire), 32'h0);
    end
    @(negedge clk);
    reset_n = 1'b1;

`ifdef DSP_SEQ_SINGLE_STEP_EN
    // Two step edges while halted give exactly two retirements.
    wait_fixed = 0;
    fill_mem(16'h0003);
    hold_reset();
    halt_req = 1'b1;
    reset_n = 1'b1;
    cnt = 0;
    while (cnt < 20 && !halted) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (cnt >= 20) fail_now("g_halt_timeout");
    cnt = 0;
    for (int s = 0; s < 2; s++) begin
      step = 1'b1;
      for (int c = 0; c < 12; c++) begin
        @(posedge clk); #1;
        if (retire) cnt++;
      end
      step = 1'b0;
      repeat (2) begin
        @(posedge clk); #1;
        if (retire) cnt++;
      end
    end
    chk("g_step_retires", 32'(cnt), 32'h2);
    chk("g_still_halted", 32'(halted), 32'h1);
    halt_req = 1'b0;
`endif

    // Randomized programs against the reference model.
    for (int run = 0; run < 3; run++) begin
      for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
      rand_wait = 1'b1; spurious_en = 1'b1;
      hold_reset();
      halt_req = 1'b0;
      build_model(154);
      mon_en = 1'b1; rand_halt_en = 1'b1;
      reset_n = 1'b1;
      wait_retires(150, 6000, ok);
      if (!ok) fail_now("rand_retire_timeout");
      @(negedge clk);
      mon_en = 1'b0; rand_halt_en = 1'b0;
      halt_req = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
